trap_ctrl: RTL and testbench

- Trap/return sequencer in the MEM/WB stage, directly upstream of the CSR file.
- Detects a pending machine-timer interrupt, ecall or mret on the instruction in WB, then drives the CSR file's trap/return write and read strobes.
- Captures the redirect target (mtvec or mepc) from the CSR read data and flushes the pipeline.
- Holds a fetch redirect until the fetch stage accepts it.

---
 rtl/trap_ctrl_pkg.sv | 30 +++
 rtl/trap_ctrl_prio_enc.sv | 29 ++
 rtl/trap_ctrl.sv | 142 ++++++++++++++
 tb/tb_trap_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: CSR addresses,
// mcause codes, FSM state encoding and the decoded event type.
package trap_ctrl_pkg;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [11:0] CSR_SATP    = 12'h180;

   // mcause values
   localparam logic [63:0] ECALL_CAUSE = 64'd11;
   localparam logic [63:0] MTI_CAUSE   = 64'h8000_0000_0000_0007;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_IRQ   = 2'd1,
      EV_ECALL = 2'd2,
      EV_MRET  = 2'd3
   } trap_ev_e;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Priority selection of the event taken by the WB instruction:
// enabled timer interrupt, then ecall, then mret.
module trap_prio_enc
   import trap_ctrl_pkg::*;
(
   input  logic     en_i,
   input  logic     timer_irq_i,
   input  logic     mstatus_mie_i,
   input  logic     mie_mtie_i,
   input  logic     ecall_i,
   input  logic     mret_i,
   output trap_ev_e ev_o
);

   logic irq_pend;

   assign irq_pend = timer_irq_i & mstatus_mie_i & mie_mtie_i;

   // Pick exactly one event when evaluation is enabled
   always_comb begin
      ev_o = EV_NONE;
      if (en_i) begin
         if (irq_pend)     ev_o = EV_IRQ;
         else if (ecall_i) ev_o = EV_ECALL;
         else if (mret_i)  ev_o = EV_MRET;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer in MEM/WB: drives CSR trap/mret strobes,
// captures the redirect target from CSR read data and holds the
// fetch redirect until accepted.
module trap_ctrl #(
   parameter int unsigned       PC_W        = 32,
   parameter int unsigned       XLEN        = 64,
   parameter logic [XLEN-1:0]   ECALL_CAUSE = trap_ctrl_pkg::ECALL_CAUSE,
   parameter logic [XLEN-1:0]   MTI_CAUSE   = trap_ctrl_pkg::MTI_CAUSE
) (
   input  logic            I_sys_clk,
   input  logic            I_rst,
   input  logic            I_MEM_WB_valid,
   input  logic [PC_W-1:0] I_MEM_WB_pc,
   input  logic            I_ecall,
   input  logic            I_mret,
   input  logic            I_mstatus_mie,
   input  logic            I_mie_mtie,
   input  logic            I_timer_irq,
   input  logic [XLEN-1:0] I_csr_rd_data,
   input  logic            I_fetch_ready,
   output logic            O_csr_intr_wr,
   output logic            O_csr_intr_rd,
   output logic [XLEN-1:0] O_csr_intr_no,
   output logic [PC_W-1:0] O_intr_pc,
   output logic            O_csr_mret_wr,
   output logic            O_csr_mret_rd,
   output logic            O_wb_kill,
   output logic            O_flush,
   output logic            O_busy,
   output logic            O_redirect_valid,
   output logic [PC_W-1:0] O_redirect_pc,
   output logic [31:0]     O_trap_cnt
);

   import trap_ctrl_pkg::*;

   state_e          state_q;
   logic            redirect_valid_q;
   logic [PC_W-1:0] redirect_pc_q;
   logic [PC_W-1:0] redirect_pc_d;
   logic [31:0]     trap_cnt_q;
   logic            ev_en;
   trap_ev_e        ev;

   // Reset also gates the strobes so every output is 0 during reset
   assign ev_en = (state_q == IDLE) & I_MEM_WB_valid & ~I_rst;

   trap_prio_enc u_prio (
      .en_i          (ev_en),
      .timer_irq_i   (I_timer_irq),
      .mstatus_mie_i (I_mstatus_mie),
      .mie_mtie_i    (I_mie_mtie),
      .ecall_i       (I_ecall),
      .mret_i        (I_mret),
      .ev_o          (ev)
   );

   generate
      if (XLEN > PC_W) begin : g_unused_hi
         logic unused_rd_hi;
         assign unused_rd_hi = ^I_csr_rd_data[XLEN-1:PC_W];
      end
   endgenerate

   // CSR strobes, cause/epc and flush, asserted in the event cycle
   always_comb begin
      O_csr_intr_wr = 1'b0;
      O_csr_intr_rd = 1'b0;
      O_csr_intr_no = '0;
      O_intr_pc     = '0;
      O_csr_mret_wr = 1'b0;
      O_csr_mret_rd = 1'b0;
      O_wb_kill     = 1'b0;
      O_flush       = 1'b0;
      case (ev)
         EV_IRQ: begin
            O_csr_intr_wr = 1'b1;
            O_csr_intr_rd = 1'b1;
            O_csr_intr_no = MTI_CAUSE;
            O_intr_pc     = I_MEM_WB_pc;
            O_wb_kill     = 1'b1;
            O_flush       = 1'b1;
         end
         EV_ECALL: begin
            O_csr_intr_wr = 1'b1;
            O_csr_intr_rd = 1'b1;
            O_csr_intr_no = ECALL_CAUSE;
            O_intr_pc     = I_MEM_WB_pc;
            O_flush       = 1'b1;
         end
         EV_MRET: begin
            O_csr_mret_wr = 1'b1;
            O_csr_mret_rd = 1'b1;
            O_flush       = 1'b1;
         end
         default: ;
      endcase
   end

   // Redirect target: mtvec is direct mode only, so clear its low bits
   always_comb begin
      redirect_pc_d = I_csr_rd_data[PC_W-1:0];
      if (ev != EV_MRET) redirect_pc_d[1:0] = 2'b00;
   end

   // FSM with registered redirect request, target and trap counter
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q          <= IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         trap_cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ev != EV_NONE) begin
                  state_q          <= REDIRECT;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= redirect_pc_d;
                  if (ev != EV_MRET) trap_cnt_q <= trap_cnt_q + 32'd1;
               end
            end
            REDIRECT: begin
               if (I_fetch_ready) begin
                  state_q          <= IDLE;
                  redirect_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q          <= IDLE;
               redirect_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign O_busy           = redirect_valid_q;
   assign O_redirect_valid = redirect_valid_q;
   assign O_redirect_pc    = redirect_pc_q;
   assign O_trap_cnt       = trap_cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed test-plan vectors followed by
// random traffic, checked against an event-level reference model.
module tb_trap_ctrl;

   logic        clk;
   logic        rst, valid, ecall, mret, mie, mtie, irq, fr;
   logic [31:0] pc;
   logic [63:0] rd;

   logic        intr_wr, intr_rd, mret_wr, mret_rd, wb_kill, flush, busy, rv;
   logic [63:0] intr_no;
   logic [31:0] intr_pc, rpc, cnt;

   trap_ctrl #(.PC_W(32), .XLEN(64)) dut (
      .I_sys_clk        (clk),
      .I_rst            (rst),
      .I_MEM_WB_valid   (valid),
      .I_MEM_WB_pc      (pc),
      .I_ecall          (ecall),
      .I_mret           (mret),
      .I_mstatus_mie    (mie),
      .I_mie_mtie       (mtie),
      .I_timer_irq      (irq),
      .I_csr_rd_data    (rd),
      .I_fetch_ready    (fr),
      .O_csr_intr_wr    (intr_wr),
      .O_csr_intr_rd    (intr_rd),
      .O_csr_intr_no    (intr_no),
      .O_intr_pc        (intr_pc),
      .O_csr_mret_wr    (mret_wr),
      .O_csr_mret_rd    (mret_rd),
      .O_wb_kill        (wb_kill),
      .O_flush          (flush),
      .O_busy           (busy),
      .O_redirect_valid (rv),
      .O_redirect_pc    (rpc),
      .O_trap_cnt       (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        intr_wr;
      logic        intr_rd;
      logic [63:0] intr_no;
      logic [31:0] intr_pc;
      logic        mret_wr;
      logic        mret_rd;
      logic        wb_kill;
      logic        flush;
      logic        busy;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] cnt;
   } exp_t;

   exp_t        eq[$];   // per-cycle expected outputs
   logic [31:0] rq[$];   // expected redirect targets, popped on handshake

   int total = 0;
   int bad   = 0;

   // model state: is a redirect outstanding, its target, traps taken
   bit          m_busy = 1'b0;
   logic [31:0] m_tgt  = '0;
   logic [31:0] m_cnt  = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus plus the reference model's view of that clock
   task automatic cyc(input bit r, input bit v, input bit ec, input bit mr,
                      input bit ti, input bit me, input bit mt,
                      input logic [31:0] p, input logic [63:0] d, input bit f);
      exp_t e;
      int   ev;
      @(posedge clk);
      #1;
      rst = r; valid = v; ecall = ec; mret = mr; irq = ti;
      mie = me; mtie = mt; pc = p; rd = d; fr = f;

      e      = '0;
      e.busy = m_busy;
      e.rv   = m_busy;
      e.rpc  = m_tgt;
      e.cnt  = m_cnt;

      ev = 0;
      if (!r && !m_busy && v) begin
         if (ti && me && mt) ev = 1;
         else if (ec)        ev = 2;
         else if (mr)        ev = 3;
      end
      if (ev == 1 || ev == 2) begin
         e.intr_wr = 1'b1;
         e.intr_rd = 1'b1;
         e.intr_no = (ev == 1) ? 64'h8000_0000_0000_0007 : 64'd11;
         e.intr_pc = p;
         e.wb_kill = (ev == 1);
         e.flush   = 1'b1;
      end else if (ev == 3) begin
         e.mret_wr = 1'b1;
         e.mret_rd = 1'b1;
         e.flush   = 1'b1;
      end
      eq.push_back(e);

      if (r) begin
         if (m_busy && !f) rq.delete();   // abandoned redirect
         m_busy = 1'b0;
         m_tgt  = '0;
         m_cnt  = '0;
      end else if (m_busy) begin
         if (f) m_busy = 1'b0;
      end else if (ev != 0) begin
         m_busy = 1'b1;
         m_tgt  = (ev == 3) ? d[31:0] : (d[31:0] & 32'hFFFF_FFFC);
         rq.push_back(m_tgt);
         if (ev != 3) m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic idle(input bit f);
      cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0, f);
   endtask

   // Monitor: compares every presented cycle and every accepted redirect
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #6;
         if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("intr_wr", intr_wr, e.intr_wr);
            chk("intr_rd", intr_rd, e.intr_rd);
            chk("intr_no", intr_no, e.intr_no);
            chk("intr_pc", intr_pc, e.intr_pc);
            chk("mret_wr", mret_wr, e.mret_wr);
            chk("mret_rd", mret_rd, e.mret_rd);
            chk("wb_kill", wb_kill, e.wb_kill);
            chk("flush", flush, e.flush);
            chk("busy", busy, e.busy);
            chk("redirect_valid", rv, e.rv);
            chk("redirect_pc", rpc, e.rpc);
            chk("trap_cnt", cnt, e.cnt);
         end
         if (rv === 1'b1 && fr === 1'b1) begin
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL redirect_handshake: got target %0h expected none", rpc);
            end else begin
               chk("redirect_target", rpc, rq.pop_front());
            end
         end
      end
   end

   // Driver
   initial begin
      rst = 1'b1; valid = 0; ecall = 0; mret = 0; irq = 0;
      mie = 0; mtie = 0; pc = '0; rd = '0; fr = 0;
      repeat (2) @(posedge clk);

      // reset holds everything at zero even with an event present
      cyc(1, 1, 1, 0, 0, 0, 0, 32'h8000_0100, 64'h8000_0003, 0);
      idle(0);

      // ecall
      cyc(0, 1, 1, 0, 0, 0, 0, 32'h8000_0100, 64'h8000_0003, 0);
      idle(1);
      idle(0);

      // mret
      cyc(0, 1, 0, 1, 0, 0, 0, 32'h8000_0300, 64'h8000_0104, 1);
      idle(1);

      // interrupt wins over ecall
      cyc(0, 1, 1, 0, 1, 1, 1, 32'h8000_0200, 64'h8000_0010, 0);
      idle(1);

      // masked interrupt: MIE=0, then MTIE=0
      cyc(0, 1, 0, 0, 1, 0, 1, 32'h8000_0400, 64'h1234, 1);
      cyc(0, 1, 0, 0, 1, 1, 0, 32'h8000_0404, 64'h1234, 1);
      idle(0);

      // backpressure with events injected while redirecting
      cyc(0, 1, 1, 0, 0, 0, 0, 32'h8000_0500, 64'h9000_0007, 0);
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 1, 0, 1, 1, 1, 32'h8000_0600, 64'hFFFF_FFFF, 0);
      idle(1);
      idle(0);

      // reset mid-redirect
      cyc(0, 1, 1, 0, 0, 0, 0, 32'h8000_0700, 64'h8000_0020, 0);
      idle(0);
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0, 0);
      idle(0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) != 0),
             $urandom, {$urandom, $urandom},
             ($urandom_range(0, 1) == 1));
      end

      // drain any outstanding redirect
      idle(1);
      idle(1);

      @(posedge clk);
      #8;
      chk("cycle_queue_empty", eq.size(), 0);
      chk("redirect_queue_empty", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
